// File: rtl/mem_map_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the I/O window register offsets, the STATUS bit layout and the
// region-select encoding produced by the address decoder.
package mem_map_pkg;

    // Word offsets of the I/O registers relative to IO_BASE.
    localparam int unsigned IO_OUT_OFS = 0;
    localparam int unsigned CYCLE_OFS  = 1;
    localparam int unsigned STATUS_OFS = 2;

    // STATUS register bit holding the sticky address-error flag.
    localparam int unsigned ERR_BIT = 0;

    typedef enum logic [2:0] {
        RegionRam,
        RegionIoOut,
        RegionCycle,
        RegionStatus,
        RegionUnmapped
    } region_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus.
//   addr  : word address from the CPU
//   wdata : write data from the CPU
//   we    : write enable (low = read)
//   rdata : registered read data back to the CPU
// master = CPU side, slave = memory responder side.
interface data_mem_responder_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM, write-first, one-cycle read latency.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : read data, registered; returns wdata on a write cycle
// Contents are not reset.
module dmem_ram #(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    logic [15:0] mem [0:(2**ADDR_BITS)-1];
    logic [15:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = we ? wdata : mem[addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface: word RAM plus a small
// memory-mapped I/O window (output port, cycle counter, sticky error status).
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   bus      : CPU bus (addr, wdata, we in; rdata out, 1-cycle latency)
//   io_out   : memory-mapped output port register
//   addr_err : sticky flag, set by any access to an unmapped address
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8,
    parameter logic [15:0] IO_BASE   = 16'hFF00
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic [15:0]          io_out,
    output logic                 addr_err
);

    localparam logic [16:0] RamWords = 17'(2 ** ADDR_BITS);

    region_e     region;
    region_e     region_d, region_q;
    logic        wr;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [15:0] io_out_d, io_out_q;
    logic [15:0] cycle_d, cycle_q;
    logic        err_d, err_q;
    logic [15:0] io_rdata_d, io_rdata_q;

    always_comb begin
        region = RegionUnmapped;
        if ({1'b0, bus.addr} < RamWords) begin
            region = RegionRam;
        end else if (bus.addr == IO_BASE + 16'(IO_OUT_OFS)) begin
            region = RegionIoOut;
        end else if (bus.addr == IO_BASE + 16'(CYCLE_OFS)) begin
            region = RegionCycle;
        end else if (bus.addr == IO_BASE + 16'(STATUS_OFS)) begin
            region = RegionStatus;
        end
    end

    // Writes presented during reset are dropped everywhere, RAM included.
    assign wr     = bus.we & ~rst;
    assign ram_we = wr & (region == RegionRam);

    dmem_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.addr[ADDR_BITS-1:0]),
        .wdata (bus.wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        region_d = region;

        io_out_d = io_out_q;
        if (wr && region == RegionIoOut) begin
            io_out_d = bus.wdata;
        end

        cycle_d = cycle_q + 16'd1;
        if (wr && region == RegionCycle) begin
            cycle_d = 16'd0;
        end

        // Set has priority over clear.
        err_d = err_q;
        if (wr && region == RegionStatus && bus.wdata[ERR_BIT]) begin
            err_d = 1'b0;
        end
        if (region == RegionUnmapped) begin
            err_d = 1'b1;
        end

        // IO read data: write-first for IO_OUT and STATUS, pre-increment for CYCLE.
        io_rdata_d = 16'd0;
        case (region)
            RegionIoOut:  io_rdata_d = io_out_d;
            RegionCycle:  io_rdata_d = (wr) ? 16'd0 : cycle_q;
            RegionStatus: io_rdata_d = {15'd0, err_d};
            default:      io_rdata_d = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            region_q   <= RegionUnmapped;
            io_out_q   <= 16'd0;
            cycle_q    <= 16'd0;
            err_q      <= 1'b0;
            io_rdata_q <= 16'd0;
        end else begin
            region_q   <= region_d;
            io_out_q   <= io_out_d;
            cycle_q    <= cycle_d;
            err_q      <= err_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    // Reset parks region_q on Unmapped so the discarded read returns 0.
    always_comb begin
        bus.rdata = (region_q == RegionRam) ? ram_rdata : io_rdata_q;
    end

    assign io_out   = io_out_q;
    assign addr_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] io_out;
    logic        addr_err;

    int unsigned n_total;
    int unsigned n_pass;

    typedef struct {
        bit          chk;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];

    data_mem_responder_if bus ();

    data_mem_responder #(
        .ADDR_BITS (8),
        .IO_BASE   (16'hFF00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .io_out   (io_out),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: push the expected rdata when driven, pop/compare after the edge.
    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w,
                          input bit chk, input logic [15:0] exp, input string nm);
        sb_t e;
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = w;
        sb.push_back('{chk: chk, exp: exp});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk) begin
            n_total++;
            if (bus.rdata !== e.exp) begin
                $display("FAIL %s: rdata=%h expected=%h", nm, bus.rdata, e.exp);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            access(16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, "idle");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        access(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, "rst0");
        access(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, "reset_rdata");
        n_total++;
        if (io_out !== 16'h0000) $display("FAIL reset_io_out: got=%h expected=0000", io_out);
        else n_pass++;
        n_total++;
        if (addr_err !== 1'b0) $display("FAIL reset_addr_err: got=%b expected=0", addr_err);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_counter;
        logic [15:0] start;
        // 10 idle edges after reset (counter 0 -> 10), reading addr 3 which is written later.
        for (int i = 0; i < 10; i++) begin
            access(16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, "idle");
        end
        access(16'hFF01, 16'h0000, 1'b0, 1'b1, 16'd10, "cycle_after_10");
        access(16'hFF01, 16'h5555, 1'b1, 1'b1, 16'd0, "cycle_write_returns0");
        access(16'hFF01, 16'h0000, 1'b0, 1'b1, 16'd0, "cycle_read_after_clear");
        access(16'hFF01, 16'h0000, 1'b0, 1'b1, 16'd1, "cycle_resumes");
        // Wrap: 65536 edges between two reads return the same value.
        start = 16'd2;
        access(16'hFF01, 16'h0000, 1'b0, 1'b1, start, "cycle_wrap_start");
        idle(65535);
        access(16'hFF01, 16'h0000, 1'b0, 1'b1, start, "cycle_wrap_end");
    endtask

    task automatic test_ram;
        access(16'h0003, 16'hA5A5, 1'b1, 1'b1, 16'hA5A5, "ram_write_first");
        access(16'h0003, 16'h0000, 1'b0, 1'b1, 16'hA5A5, "ram_read3");
        access(16'h0000, 16'h5A5A, 1'b1, 1'b1, 16'h5A5A, "ram_write0");
        access(16'h0005, 16'h1234, 1'b1, 1'b1, 16'h1234, "ram_write5");
        access(16'h00FF, 16'hC3C3, 1'b1, 1'b1, 16'hC3C3, "ram_write_top");
        access(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h5A5A, "ram_read0");
        access(16'h00FF, 16'h0000, 1'b0, 1'b1, 16'hC3C3, "ram_read_top");
    endtask

    task automatic test_io;
        access(16'hFF00, 16'h00FF, 1'b1, 1'b1, 16'h00FF, "io_write_rdata");
        n_total++;
        if (io_out !== 16'h00FF) $display("FAIL io_out_after_write: got=%h expected=00ff", io_out);
        else n_pass++;
        access(16'hFF00, 16'h0000, 1'b0, 1'b1, 16'h00FF, "io_read");
        // A read must not disturb io_out.
        n_total++;
        if (io_out !== 16'h00FF) $display("FAIL io_out_hold: got=%h expected=00ff", io_out);
        else n_pass++;
    endtask

    task automatic test_unmapped;
        access(16'h1234, 16'h0000, 1'b0, 1'b1, 16'h0000, "unmapped_read");
        n_total++;
        if (addr_err !== 1'b1) $display("FAIL err_set: got=%b expected=1", addr_err);
        else n_pass++;
        idle(3);
        n_total++;
        if (addr_err !== 1'b1) $display("FAIL err_sticky: got=%b expected=1", addr_err);
        else n_pass++;
        access(16'hFF02, 16'h0000, 1'b1, 1'b1, 16'h0001, "status_write0");
        n_total++;
        if (addr_err !== 1'b1) $display("FAIL err_write0: got=%b expected=1", addr_err);
        else n_pass++;
        access(16'hFF02, 16'h0001, 1'b1, 1'b1, 16'h0000, "status_clear_rdata");
        n_total++;
        if (addr_err !== 1'b0) $display("FAIL err_clear: got=%b expected=0", addr_err);
        else n_pass++;
        access(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0000, "status_read");
        access(16'h0200, 16'hBEEF, 1'b1, 1'b1, 16'h0000, "unmapped_write");
        n_total++;
        if (addr_err !== 1'b1) $display("FAIL err_unmapped_write: got=%b expected=1", addr_err);
        else n_pass++;
        access(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0001, "status_read_set");
        access(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h5A5A, "ram0_untouched");
        access(16'hFF03, 16'h0000, 1'b0, 1'b1, 16'h0000, "unmapped_ff03");
    endtask

    task automatic test_reset_write;
        rst = 1'b1;
        access(16'h0005, 16'h1111, 1'b1, 1'b1, 16'h0000, "reset_write_rdata");
        n_total++;
        if (io_out !== 16'h0000) $display("FAIL reset_io_clear: got=%h expected=0000", io_out);
        else n_pass++;
        n_total++;
        if (addr_err !== 1'b0) $display("FAIL reset_err_clear: got=%b expected=0", addr_err);
        else n_pass++;
        rst = 1'b0;
        access(16'hFF01, 16'h0000, 1'b0, 1'b1, 16'h0000, "cycle_after_reset");
        access(16'h0005, 16'h0000, 1'b0, 1'b1, 16'h1234, "ram5_kept");
        access(16'hFF00, 16'h0000, 1'b0, 1'b1, 16'h0000, "io_read_after_reset");
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [4];
        for (int i = 0; i < 4; i++) begin
            vals[i] = 16'($urandom);
            access(16'(16 + i), vals[i], 1'b1, 1'b1, vals[i], "b2b_write");
        end
        for (int i = 3; i >= 0; i--) begin
            access(16'(16 + i), 16'h0000, 1'b0, 1'b1, vals[i], "b2b_read");
        end
        access(16'h0003, 16'h0000, 1'b0, 1'b1, 16'hA5A5, "b2b_mix_ram");
        access(16'hFF00, 16'h0F0F, 1'b1, 1'b1, 16'h0F0F, "b2b_mix_io");
        access(16'h0013, 16'h0000, 1'b0, 1'b1, vals[3], "b2b_mix_ram2");
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b0;
        bus.addr  = 16'h0000;
        bus.wdata = 16'h0000;
        bus.we    = 1'b0;
        test_reset();
        test_counter();
        test_ram();
        test_io();
        test_unmapped();
        test_reset_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface. Receives address, write data and write enable from the pipelined CPU; returns read data with a registered response.
- Combines a single-port word RAM with a small memory-mapped I/O window: an output port, a free-running cycle counter, and a sticky address-error status.
- Sits beside the CPU at top level. CPU addr/data_out/we drive this block; this block's rdata drives the CPU's data_in.

Parameters:
- ADDR_BITS, 8, RAM depth is 2**ADDR_BITS 16-bit words at word addresses 0 .. 2**ADDR_BITS-1 (legal 1..15).
- IO_BASE, 16'hFF00, base word address of the I/O window. Must lie above the RAM range.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- addr  input  16  Word address from the CPU.
- wdata  input  16  Write data from the CPU.
- we  input  1  Write enable. When low, the access is a read.
- rdata  output  16  Registered read data to the CPU.
- io_out  output  16  Memory-mapped output port register.
- addr_err  output  1  Sticky flag: an access hit an unmapped address.

Behaviour:
- Address decode (combinational on addr):
  - RAM when addr < 2**ADDR_BITS.
  - IO_OUT at IO_BASE+0: read/write.
  - CYCLE at IO_BASE+1: read-only counter; any write clears it.
  - STATUS at IO_BASE+2: bit0 = addr_err, other bits read 0. Writing 1 to bit0 clears addr_err; writing 0 has no effect.
  - Every other address is UNMAPPED.
- Every cycle is an access. There is no valid strobe, matching the CPU, which always presents addr.
- Read latency is 1 cycle: rdata at edge N+1 reflects addr sampled at edge N.
- Writes: when we=1 at edge N, the target updates at edge N.
  - For RAM and IO_OUT, rdata after that same edge returns the newly written value (write-first).
  - CYCLE write: the counter becomes 0 at edge N, and rdata returns 0.
  - STATUS write: rdata returns the post-clear value.
- Cycle counter:
  - 16-bit; increments by 1 every cycle not in reset and not being written.
  - Wraps 16'hFFFF -> 16'h0000 with no flag.
  - A read returns the value before that edge's increment.
- Unmapped access: rdata returns 16'h0000 and writes are dropped. addr_err sets at that edge and stays set until cleared or reset.
  - If a STATUS clear and an unmapped access occur in the same cycle, set wins. This cannot actually happen, because one address is presented per cycle.
- Reset (rst=1 at an edge):
  - rdata=0, io_out=0, CYCLE=0, addr_err=0.
  - Any write presented in that cycle is ignored, including RAM writes.
  - RAM contents are NOT cleared.
  - Reset mid-operation simply discards the in-flight read: rdata is 0 on the following cycle.
- io_out is a direct register output. It changes at the write edge.
- RAM reads of never-written locations are undefined. The bench must write before reading.

Decomposition:
- Package mem_map_pkg:
  - Localparams for the IO offsets: IO_OUT_OFS=0, CYCLE_OFS=1, STATUS_OFS=2.
  - STATUS bit index ERR_BIT=0.
  - Region-select encoding: RAM, IO_OUT, CYCLE, STATUS, UNMAPPED as a 3-bit enum.
- Sub-module dmem_ram:
  - Single-port synchronous RAM with parameter ADDR_BITS.
  - Ports clk, we, addr[ADDR_BITS-1:0], wdata, rdata.
  - Write-first, 1-cycle read, no reset.
- The top block holds the decode, the IO registers, the counter and the rdata output mux. The mux selects on the region registered alongside the address.

Test Plan:
- Reset, then write 16'hA5A5 to RAM addr 3 and read addr 3 on the next cycle -> rdata=16'hA5A5 one cycle after the read address; a same-cycle write/read of addr 3 returns 16'hA5A5.
- Write 16'h00FF to IO_BASE (16'hFF00) -> io_out=16'h00FF after that edge; a read of 16'hFF00 returns 16'h00FF; asserting rst clears io_out to 0.
- Hold 10 idle cycles after reset, then read 16'hFF01 -> rdata=10. Write any value to 16'hFF01 -> the next read returns 0, then counting resumes. Preload-free wrap check: run 65536 cycles -> the count returns to its start value.
- Read 16'h1234 (unmapped with ADDR_BITS=8) -> rdata=0 and addr_err=1 the next cycle; it stays 1 across idle cycles. A write of 16'h0001 to 16'hFF02 -> addr_err=0; a write of 16'h0000 leaves it set.
- Write 16'hBEEF to 16'h0200 (unmapped) -> RAM addr 0 remains unchanged and addr_err=1. Assert rst while we=1 to addr 5 with 16'h1111 -> RAM addr 5 keeps its previous value and rdata=0 after the reset edge.
